// File: rtl/led_bar_monitor_if.sv
// led_bar_monitor_if: signal bundle between an LED-bar source and its monitor.
//  master drives LED, clr_err, flick_en, flick_lvl and observes the decoded results.
//  slave (the monitor) observes LED and controls, drives level, dir_up, turn_pulse,
//  peak_level, phase_cnt, err_code, err_step, stall, FLICK.
interface led_bar_monitor_if #(parameter int WIDTH = 16, parameter int PHASE_W = 4);
  localparam int LW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] LED;
  logic clr_err;
  logic flick_en;
  logic [LW-1:0] flick_lvl;
  logic [LW-1:0] level;
  logic dir_up;
  logic turn_pulse;
  logic [LW-1:0] peak_level;
  logic [PHASE_W-1:0] phase_cnt;
  logic err_code;
  logic err_step;
  logic stall;
  logic FLICK;
  modport master(output LED, clr_err, flick_en, flick_lvl,
                 input level, dir_up, turn_pulse, peak_level, phase_cnt, err_code, err_step, stall, FLICK);
  modport slave(input LED, clr_err, flick_en, flick_lvl,
                output level, dir_up, turn_pulse, peak_level, phase_cnt, err_code, err_step, stall, FLICK);
endinterface

// File: rtl/led_bar_monitor.sv
// led_bar_monitor: decodes a thermometer-coded LED bar into a level and tracks its sweep.
//  CLK, RST (async, active-high) plus bus (led_bar_monitor_if.slave):
//  in: LED, clr_err, flick_en, flick_lvl; out: level, dir_up, turn_pulse, peak_level,
//  phase_cnt, err_code, err_step, stall, FLICK.
//  Optional FLICK generator enabled by defining LED_MON_FLICK_GEN_EN; otherwise FLICK = 0.
module led_bar_monitor #(
  parameter int WIDTH = 16,
  parameter int PHASE_W = 4,
  parameter int STALL_MAX = 64
) (
  input logic CLK,
  input logic RST,
  led_bar_monitor_if.slave bus
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(STALL_MAX + 1);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t r_state, w_state_n;
  logic [WIDTH-1:0] r_smp;
  logic r_clr;
  logic [LW-1:0] r_level, r_peak, w_new;
  logic [PHASE_W-1:0] r_phase;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic r_turn, r_ec, r_es, r_stall;
  logic w_valid, w_up, w_dn, w_chg, w_step, w_turn, w_hit;
  always_comb begin
    w_new = '0;
    for (int i = 0; i < WIDTH; i++) w_new = w_new + LW'(r_smp[i]);
    w_valid = (r_smp & (r_smp + WIDTH'(1))) == '0;
    w_up = w_valid && (w_new > r_level);
    w_dn = w_valid && (w_new < r_level);
    w_chg = w_up || w_dn;
    w_step = (w_up && ((LW+1)'(w_new) > (LW+1)'(r_level) + (LW+1)'(1))) ||
             (w_dn && ((LW+1)'(r_level) > (LW+1)'(w_new) + (LW+1)'(1)));
    w_cnt_n = w_chg ? '0 : (r_cnt == CW'(STALL_MAX)) ? r_cnt : r_cnt + CW'(1);
    w_hit = w_cnt_n == CW'(STALL_MAX);
    w_turn = ((r_state == UP) && w_dn) || ((r_state == DOWN) && w_up);
    w_state_n = w_hit ? IDLE : w_up ? UP : w_dn ? DOWN : r_state;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_state_n;
  // clr_err travels with its LED sample so a clear lines up with the sample it accompanies
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_smp <= '0;
      r_clr <= 1'b0;
      r_level <= '0;
      r_peak <= '0;
      r_phase <= '0;
      r_cnt <= '0;
      r_turn <= 1'b0;
      r_ec <= 1'b0;
      r_es <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_smp <= bus.LED;
      r_clr <= bus.clr_err;
      if (w_valid) r_level <= w_new;
      if (w_turn) r_peak <= r_level;
      r_phase <= w_hit ? '0 : r_phase + PHASE_W'(w_turn);
      r_cnt <= w_cnt_n;
      r_turn <= w_turn;
      r_ec <= !w_valid || (r_ec && !r_clr);
      r_es <= w_step || (r_es && !r_clr);
      r_stall <= w_hit;
    end
`ifdef LED_MON_FLICK_GEN_EN
  logic r_flick;
  // a real change onto flick_lvl fires; staying there does not, so it re-arms once level moves away
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_flick <= 1'b0;
    else r_flick <= bus.flick_en && w_chg && (w_new == bus.flick_lvl);
  assign bus.FLICK = r_flick;
`else
  assign bus.FLICK = 1'b0;
`endif
  assign bus.level = r_level;
  assign bus.dir_up = r_state == UP;
  assign bus.turn_pulse = r_turn;
  assign bus.peak_level = r_peak;
  assign bus.phase_cnt = r_phase;
  assign bus.err_code = r_ec;
  assign bus.err_step = r_es;
  assign bus.stall = r_stall;
endmodule
